// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of a 5-stage pipeline. Holds the program counter,
//   applies branch/jump redirects, and owns the IF/ID pipeline register.
//   A redirect that arrives while the PC is stalled is parked in a pending
//   register (FSM state HOLD) and applied on the first unstalled cycle.
//
// Configuration macro:
//   BRANCH_FLUSH_EN - when defined, the wrong-path instruction fetched in the
//                     redirect cycle (or the cycle leaving HOLD) is squashed
//                     into a bubble. When undefined, that instruction enters ID
//                     normally (one architectural delay slot).
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   Stall_IF          hold the PC this cycle
//   Stall_ID          hold the IF/ID register this cycle (overrides flush)
//   Branch_Taken/Branch_Target, Jump/Jump_Target
//                     redirect requests from ID; Jump has priority
//   Instruction_Mem   combinational instruction-memory data for PC_out
//   PC_out            current fetch address (the PC register itself)
//   Instruction_ID, PC_Plus4_ID, Valid_ID
//                     IF/ID register contents
//   Redirect_Pending  high while a stalled redirect is parked (state HOLD)
//   o_dbg_state       FSM state for observation (0 = RUN, 1 = HOLD)
//
// There is no valid/ready handshake here: flow control is by the two stall
// inputs only. A stall input high means the corresponding register keeps its
// value on the next edge; low means it loads.
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall_IF,
    input  logic        Stall_ID,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    input  logic        Jump,
    input  logic [31:0] Jump_Target,
    input  logic [31:0] Instruction_Mem,
    output logic [31:0] PC_out,
    output logic [31:0] Instruction_ID,
    output logic [31:0] PC_Plus4_ID,
    output logic        Valid_ID,
    output logic        Redirect_Pending,
    output logic        o_dbg_state
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pending;
    logic [31:0] r_instr_id;
    logic [31:0] r_pc4_id;
    logic        r_valid_id;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic        w_leave_hold;
    logic        w_flush;

    assign w_redirect   = Jump | Branch_Taken;
    assign w_target     = Jump ? Jump_Target : Branch_Target;
    // 32-bit add wraps naturally at the top of the address space.
    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_leave_hold = (r_state == HOLD) && !Stall_IF;

`ifdef BRANCH_FLUSH_EN
    assign w_flush = w_redirect | w_leave_hold;
`else
    assign w_flush = 1'b0;
`endif

    // PC and redirect FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_pending <= 32'h0;
            r_state   <= RUN;
        end else if (!Stall_IF) begin
            // A fresh redirect beats a parked one: it is the newer decision.
            if (w_redirect) begin
                r_pc <= w_target;
            end else if (r_state == HOLD) begin
                r_pc <= r_pending;
            end else begin
                r_pc <= w_pc_plus4;
            end
            r_state <= RUN;
        end else if (w_redirect) begin
            // PC is frozen; park the target. Later redirects overwrite it.
            r_pending <= w_target;
            r_state   <= HOLD;
        end
    end

    // IF/ID pipeline register. Stall_ID wins over any flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_id <= NOP_WORD;
            r_pc4_id   <= 32'h0;
            r_valid_id <= 1'b0;
        end else if (!Stall_ID) begin
            if (w_flush) begin
                r_instr_id <= NOP_WORD;
                r_pc4_id   <= 32'h0;
                r_valid_id <= 1'b0;
            end else begin
                r_instr_id <= Instruction_Mem;
                r_pc4_id   <= w_pc_plus4;
                r_valid_id <= 1'b1;
            end
        end
    end

    assign PC_out           = r_pc;
    assign Instruction_ID   = r_instr_id;
    assign PC_Plus4_ID      = r_pc4_id;
    assign Valid_ID         = r_valid_id;
    assign Redirect_Pending = (r_state == HOLD);
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int N = 20;
`ifdef BRANCH_FLUSH_EN
  localparam bit F = 1'b1;
`else
  localparam bit F = 1'b0;
`endif

  typedef struct {
    logic        sif;
    logic        sid;
    logic        bt;
    logic [31:0] btgt;
    logic        j;
    logic [31:0] jt;
    logic [31:0] mem;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic [31:0] e_pc4;
    logic        e_v;
    logic        e_pend;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_if, stall_id, branch_taken, jump;
  logic [31:0] branch_target, jump_target, instruction_mem;
  logic [31:0] pc_out, instruction_id, pc_plus4_id;
  logic        valid_id, redirect_pending, dbg_state;

  vec_t        vec[N];
  logic [97:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;

  fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .Stall_IF         (stall_if),
    .Stall_ID         (stall_id),
    .Branch_Taken     (branch_taken),
    .Branch_Target    (branch_target),
    .Jump             (jump),
    .Jump_Target      (jump_target),
    .Instruction_Mem  (instruction_mem),
    .PC_out           (pc_out),
    .Instruction_ID   (instruction_id),
    .PC_Plus4_ID      (pc_plus4_id),
    .Valid_ID         (valid_id),
    .Redirect_Pending (redirect_pending),
    .o_dbg_state      (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Outputs are compared against a literal snapshot (no queue involved).
  task automatic check_now(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ins,
                           input logic [31:0] e_pc4, input logic e_v, input logic e_pend);
    check({tag, "_pc"},   pc_out, e_pc);
    check({tag, "_ins"},  instruction_id, e_ins);
    check({tag, "_pc4"},  pc_plus4_id, e_pc4);
    check({tag, "_v"},    {31'h0, valid_id}, {31'h0, e_v});
    check({tag, "_pend"}, {31'h0, redirect_pending}, {31'h0, e_pend});
  endtask

  // Driver: apply one vector, queue its expected post-edge outputs, then
  // sample #1 after the edge and score against the queue head.
  task automatic step(input string tag, input vec_t v);
    logic [97:0] e;
    stall_if        = v.sif;
    stall_id        = v.sid;
    branch_taken    = v.bt;
    branch_target   = v.btgt;
    jump            = v.j;
    jump_target     = v.jt;
    instruction_mem = v.mem;
    exp_q.push_back({v.e_pc, v.e_ins, v.e_pc4, v.e_v, v.e_pend});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_queue actual=empty required=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check_now(tag, e[97:66], e[65:34], e[33:2], e[1], e[0]);
    end
  endtask

  initial begin
    // Expected values derived by hand from the fetch rules; F selects the
    // squashed-instruction variant when the flush feature is built in.
    vec[0]  = '{0,0,0,32'h0,0,32'h0,32'h2008_0005, 32'h0040_0004,32'h2008_0005,32'h0040_0004,1,0};
    vec[1]  = '{0,0,0,32'h0,0,32'h0,32'h2008_0006, 32'h0040_0008,32'h2008_0006,32'h0040_0008,1,0};
    vec[2]  = '{0,0,0,32'h0,0,32'h0,32'h2008_0007, 32'h0040_000C,32'h2008_0007,32'h0040_000C,1,0};
    vec[3]  = '{0,0,0,32'h0,0,32'h0,32'h0000_000A, 32'h0040_0010,32'h0000_000A,32'h0040_0010,1,0};
    vec[4]  = '{1,1,0,32'h0,0,32'h0,32'h0000_000B, 32'h0040_0010,32'h0000_000A,32'h0040_0010,1,0};
    vec[5]  = '{1,1,0,32'h0,0,32'h0,32'h0000_000B, 32'h0040_0010,32'h0000_000A,32'h0040_0010,1,0};
    vec[6]  = '{0,0,0,32'h0,0,32'h0,32'h0000_000C, 32'h0040_0014,32'h0000_000C,32'h0040_0014,1,0};
    vec[7]  = '{0,1,0,32'h0,0,32'h0,32'h0000_000D, 32'h0040_0018,32'h0000_000C,32'h0040_0014,1,0};
    vec[8]  = '{0,0,1,32'h0040_0200,1,32'h0040_0100,32'h0000_000E,
                32'h0040_0100, F ? 32'h0 : 32'h0000_000E, F ? 32'h0 : 32'h0040_001C, !F, 0};
    vec[9]  = '{0,0,0,32'h0,0,32'h0,32'h0000_000F, 32'h0040_0104,32'h0000_000F,32'h0040_0104,1,0};
    vec[10] = '{1,0,1,32'h0040_0040,0,32'h0,32'h0000_0011,
                32'h0040_0104, F ? 32'h0 : 32'h0000_0011, F ? 32'h0 : 32'h0040_0108, !F, 1};
    vec[11] = '{1,0,0,32'h0,0,32'h0,32'h0000_0012, 32'h0040_0104,32'h0000_0012,32'h0040_0108,1,1};
    vec[12] = '{0,0,0,32'h0,0,32'h0,32'h0000_0013,
                32'h0040_0040, F ? 32'h0 : 32'h0000_0013, F ? 32'h0 : 32'h0040_0108, !F, 0};
    vec[13] = '{1,0,0,32'h0,1,32'h0040_0300,32'h0000_0014,
                32'h0040_0040, F ? 32'h0 : 32'h0000_0014, F ? 32'h0 : 32'h0040_0044, !F, 1};
    vec[14] = '{1,1,1,32'h0040_0500,0,32'h0,32'h0000_0015,
                32'h0040_0040, F ? 32'h0 : 32'h0000_0014, F ? 32'h0 : 32'h0040_0044, !F, 1};
    vec[15] = '{0,0,0,32'h0,0,32'h0,32'h0000_0016,
                32'h0040_0500, F ? 32'h0 : 32'h0000_0016, F ? 32'h0 : 32'h0040_0044, !F, 0};
    vec[16] = '{0,0,0,32'h0,0,32'h0,32'h0000_0017, 32'h0040_0504,32'h0000_0017,32'h0040_0504,1,0};
    vec[17] = '{0,0,0,32'h0,1,32'hFFFF_FFFC,32'h0000_0018,
                32'hFFFF_FFFC, F ? 32'h0 : 32'h0000_0018, F ? 32'h0 : 32'h0040_0508, !F, 0};
    vec[18] = '{0,0,0,32'h0,0,32'h0,32'h0000_0019, 32'h0000_0000,32'h0000_0019,32'h0000_0000,1,0};
    vec[19] = '{1,0,1,32'h0040_0700,0,32'h0,32'h0000_001A,
                32'h0000_0000, F ? 32'h0 : 32'h0000_001A, F ? 32'h0 : 32'h0000_0004, !F, 1};

    // reset block
    reset = 1'b1;
    stall_if = 0; stall_id = 0; branch_taken = 0; jump = 0;
    branch_target = 32'h0; jump_target = 32'h0; instruction_mem = 32'h0;
    #3;
    check_now("reset", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 1'b0);
    check("reset_state", {31'h0, dbg_state}, 32'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    for (int i = 0; i < N; i++) begin
      step($sformatf("v%0d", i), vec[i]);
    end

    // A redirect is parked now; an asynchronous reset mid-cycle must clear
    // everything immediately and discard the parked target.
    check("pre_reset_state", {31'h0, dbg_state}, 32'h1);
    stall_if = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_now("midrst", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 1'b0);
    check("midrst_state", {31'h0, dbg_state}, 32'h0);
    #1;
    reset = 1'b0;
    step("post_rst", '{0,0,0,32'h0,0,32'h0,32'h0000_001B,
                       32'h0040_0004,32'h0000_001B,32'h0040_0004,1,0});

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
